// File: rtl/dadda_arb_pkg.sv
// Shared constants and state encoding for the Dadda multiplier arbiter.
package dadda_arb_pkg;
    localparam int NREQ   = 4;
    localparam int ID_W   = 2;
    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_RSP
    } state_t;
endpackage

// File: rtl/dadda_8x8.sv
// Combinational unsigned 8x8 Dadda multiplier: partial-product columns are
// compressed to heights 6,4,3,2 with full/half adders, then one 16-bit adder.
module dadda_8x8 (
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic [15:0] y
);
    always_comb begin
        logic        col  [0:16][0:7];
        logic        ncol [0:16][0:7];
        int          cnt  [0:16];
        int          ncnt [0:16];
        int          idx;
        int          d;
        logic [15:0] row0;
        logic [15:0] row1;

        for (int c = 0; c <= 16; c++) begin
            cnt[c]  = 0;
            ncnt[c] = 0;
            for (int n = 0; n < 8; n++) begin
                col[c][n]  = 1'b0;
                ncol[c][n] = 1'b0;
            end
        end
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                col[i+j][cnt[i+j]] = A[i] & B[j];
                cnt[i+j]++;
            end
        end

        for (int s = 0; s < 4; s++) begin
            d = (s == 0) ? 6 : (s == 1) ? 4 : (s == 2) ? 3 : 2;
            for (int c = 0; c <= 16; c++) begin
                ncnt[c] = 0;
                for (int n = 0; n < 8; n++) ncol[c][n] = 1'b0;
            end
            for (int c = 0; c < 16; c++) begin
                idx = 0;
                // Only compress as much as needed to hit the stage height d,
                // counting carries already pushed in from column c-1.
                for (int k = 0; k < 4; k++) begin
                    if ((cnt[c] - idx) + ncnt[c] > d) begin
                        if (((cnt[c] - idx) + ncnt[c] - d >= 2) && (cnt[c] - idx >= 3)) begin
                            ncol[c][ncnt[c]]     = col[c][idx] ^ col[c][idx+1] ^ col[c][idx+2];
                            ncol[c+1][ncnt[c+1]] = (col[c][idx] & col[c][idx+1]) |
                                                   (col[c][idx+2] & (col[c][idx] ^ col[c][idx+1]));
                            ncnt[c]++;
                            ncnt[c+1]++;
                            idx += 3;
                        end else if (cnt[c] - idx >= 2) begin
                            ncol[c][ncnt[c]]     = col[c][idx] ^ col[c][idx+1];
                            ncol[c+1][ncnt[c+1]] = col[c][idx] & col[c][idx+1];
                            ncnt[c]++;
                            ncnt[c+1]++;
                            idx += 2;
                        end
                    end
                end
                for (int n = 0; n < 8; n++) begin
                    if (n >= idx && n < cnt[c]) begin
                        ncol[c][ncnt[c]] = col[c][n];
                        ncnt[c]++;
                    end
                end
            end
            col = ncol;
            cnt = ncnt;
        end

        for (int c = 0; c < 16; c++) begin
            row0[c] = col[c][0];
            row1[c] = col[c][1];
        end
        y = row0 + row1;
    end
endmodule

// File: rtl/dadda_mul_arbiter.sv
// Four-way valid/ready arbiter in front of a shared registered Dadda multiplier.
// Define DADDA_ARB_RR_EN for round-robin grant; otherwise lowest index wins.
module dadda_mul_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NREQ-1:0]                    req_valid,
    input  logic [NREQ*8-1:0]                  req_a,
    input  logic [NREQ*8-1:0]                  req_b,
    output logic [NREQ-1:0]                    req_ready,
    output logic                               rsp_valid,
    output logic [dadda_arb_pkg::PROD_W-1:0]   rsp_y,
    output logic [dadda_arb_pkg::ID_W-1:0]     rsp_id,
    input  logic                               rsp_ready,
    output logic                               busy
);
    import dadda_arb_pkg::*;

    state_t              state_reg;
    state_t              state_next;
    logic [OP_W-1:0]     op_a_reg;
    logic [OP_W-1:0]     op_b_reg;
    logic [ID_W-1:0]     op_id_reg;
    logic [ID_W-1:0]     grant_idx;
    logic                grant_any;
    logic                can_grant;
    logic                accept;
    logic [PROD_W-1:0]   product;
`ifdef DADDA_ARB_RR_EN
    logic [ID_W-1:0]     ptr_reg;
`endif

    dadda_8x8 u_mul (
        .A (op_a_reg),
        .B (op_b_reg),
        .y (product)
    );

    // Descending scan so the candidate closest to the search start wins.
    always_comb begin
        grant_idx = '0;
        grant_any = |req_valid;
`ifdef DADDA_ARB_RR_EN
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[ptr_reg + ID_W'(k)]) grant_idx = ptr_reg + ID_W'(k);
        end
`else
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[k]) grant_idx = ID_W'(k);
        end
`endif
    end

    assign can_grant = !rst && ((state_reg == S_IDLE) || ((state_reg == S_RSP) && rsp_ready));
    assign accept    = can_grant && grant_any;
    assign busy      = (state_reg != S_IDLE);

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = accept && (grant_idx == ID_W'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (accept) state_next = S_MUL;
            S_MUL:   state_next = S_RSP;
            S_RSP:   if (rsp_ready) state_next = accept ? S_MUL : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            op_a_reg  <= '0;
            op_b_reg  <= '0;
            op_id_reg <= '0;
            rsp_valid <= 1'b0;
            rsp_y     <= '0;
            rsp_id    <= '0;
`ifdef DADDA_ARB_RR_EN
            ptr_reg   <= '0;
`endif
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_a_reg  <= req_a[8*grant_idx +: 8];
                op_b_reg  <= req_b[8*grant_idx +: 8];
                op_id_reg <= grant_idx;
`ifdef DADDA_ARB_RR_EN
                ptr_reg   <= grant_idx + 1'b1;
`endif
            end
            if (state_reg == S_MUL) begin
                rsp_valid <= 1'b1;
                rsp_y     <= product;
                rsp_id    <= op_id_reg;
            end else if ((state_reg == S_RSP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dadda_mul_arbiter.sv
// Directed and randomised checks of the shared Dadda multiplier arbiter.
module tb_dadda_mul_arbiter;
    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [15:0] rsp_y;
    logic [1:0]  rsp_id;
    logic        rsp_ready;
    logic        busy;

    int tests;
    int fails;

    typedef struct {
        logic [1:0]  id;
        logic [15:0] y;
    } exp_t;
    exp_t exp_q[$];

    dadda_mul_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_y     (rsp_y),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, tests=%0d", tests);
        $fatal(1, "timeout");
    end

    // All tasks start and end at posedge+1.
    task automatic issue(input int i, input logic [7:0] a, input logic [7:0] b, output bit ok);
        req_a[8*i +: 8] = a;
        req_b[8*i +: 8] = b;
        req_valid[i]    = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            #4;
            if (req_ready[i]) ok = 1'b1;
            @(posedge clk); #1;
        end
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            if (rsp_valid) ok = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (req_ready !== 4'b0) begin fails++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        tests++; if (rsp_y !== 16'd0) begin fails++; $display("FAIL reset_rsp_y: got %0d want 0", rsp_y); end
        tests++; if (rsp_id !== 2'd0) begin fails++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single;
        bit ok;
        rsp_ready = 1'b1;
        issue(0, 8'd200, 8'd150, ok);
        tests++; if (!ok) begin fails++; $display("FAIL single_accept: got no grant want grant on 0"); end
        tests++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin fails++; $display("FAIL single_mul_state: got busy=%b rsp_valid=%b want 1/0", busy, rsp_valid); end
        @(posedge clk); #1;
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL single_latency: got rsp_valid=%b want 1", rsp_valid); end
        tests++; if (rsp_y !== 16'd30000) begin fails++; $display("FAIL single_y: got %0d want 30000", rsp_y); end
        tests++; if (rsp_id !== 2'd0) begin fails++; $display("FAIL single_id: got %0d want 0", rsp_id); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy_rsp: got %b want 1", busy); end
        @(posedge clk); #1;
        tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL single_done: got rsp_valid=%b busy=%b want 0/0", rsp_valid, busy); end
    endtask

    task automatic test_corners;
        int          ids [3] = '{1, 2, 3};
        logic [7:0]  av  [3] = '{8'd255, 8'd0, 8'd1};
        logic [7:0]  bv  [3] = '{8'd255, 8'd173, 8'd255};
        logic [15:0] ev  [3] = '{16'd65025, 16'd0, 16'd255};
        bit ok;
        rsp_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            issue(ids[t], av[t], bv[t], ok);
            wait_rsp(ok);
            tests++; if (!ok || rsp_y !== ev[t]) begin fails++; $display("FAIL corner_y[%0d]: got %0d (valid=%b) want %0d", t, rsp_y, ok, ev[t]); end
            tests++; if (rsp_id !== 2'(ids[t])) begin fails++; $display("FAIL corner_id[%0d]: got %0d want %0d", t, rsp_id, ids[t]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_contention;
        int order [4];
        int ngr = 0;
`ifdef DADDA_ARB_RR_EN
        int target = 4;
        int expv [4] = '{0, 2, 0, 2};
`else
        int target = 3;
        int expv [4] = '{0, 0, 0, 0};
`endif
        rsp_ready = 1'b1;
        req_a[7:0] = 8'd3; req_b[7:0] = 8'd5; req_a[23:16] = 8'd7; req_b[23:16] = 8'd11;
        req_valid = 4'b0101;
        for (int c = 0; c < 40 && ngr < target; c++) begin
            #4;
            if (rsp_valid) begin
                tests++;
                if (rsp_y !== ((rsp_id == 2'd0) ? 16'd15 : 16'd77)) begin fails++; $display("FAIL contend_y: got %0d for id %0d", rsp_y, rsp_id); end
            end
            if (req_ready != 4'b0) begin
                tests++;
                if ((req_ready & ~req_valid) != 4'b0 || $countones(req_ready) != 1) begin fails++; $display("FAIL contend_onehot: got %b want one bit of %b", req_ready, req_valid); end
                for (int i = 0; i < 4; i++) if (req_ready[i]) order[ngr] = i;
                ngr++;
            end
            @(posedge clk); #1;
        end
        req_valid = 4'b0;
        tests++; if (ngr != target) begin fails++; $display("FAIL contend_count: got %0d grants want %0d", ngr, target); end
        for (int k = 0; k < ngr; k++) begin
            tests++; if (order[k] != expv[k]) begin fails++; $display("FAIL contend_order[%0d]: got %0d want %0d", k, order[k], expv[k]); end
        end
        for (int c = 0; c < 10 && busy; c++) begin @(posedge clk); #1; end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL contend_drain: got busy=%b want 0", busy); end
    endtask

    task automatic test_backpressure;
        bit ok;
        rsp_ready = 1'b0;
        issue(1, 8'd12, 8'd13, ok);
        wait_rsp(ok);
        tests++; if (!ok) begin fails++; $display("FAIL bp_rsp: got no response want one"); end
        req_a[7:0] = 8'd9; req_b[7:0] = 8'd9; req_valid = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            #4;
            tests++;
            if (rsp_valid !== 1'b1 || rsp_y !== 16'd156 || rsp_id !== 2'd1 || req_ready !== 4'b0) begin
                fails++;
                $display("FAIL bp_hold[%0d]: got valid=%b y=%0d id=%0d ready=%b want 1/156/1/0000", c, rsp_valid, rsp_y, rsp_id, req_ready);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        #4;
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL bp_release_grant: got %b want 0001", req_ready); end
        @(posedge clk); #1;
        req_valid = 4'b0;
        tests++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL bp_next_mul: got valid=%b busy=%b want 0/1", rsp_valid, busy); end
        @(posedge clk); #1;
        tests++; if (rsp_valid !== 1'b1 || rsp_y !== 16'd81 || rsp_id !== 2'd0) begin fails++; $display("FAIL bp_next_rsp: got valid=%b y=%0d id=%0d want 1/81/0", rsp_valid, rsp_y, rsp_id); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        bit ok;
        rsp_ready = 1'b1;
        issue(2, 8'd100, 8'd100, ok);
        #2 rst = 1'b1;
        #1;
        tests++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_y !== 16'd0 || rsp_id !== 2'd0 || req_ready !== 4'b0) begin
            fails++;
            $display("FAIL rstmid_async: got valid=%b busy=%b y=%0d id=%0d ready=%b want all 0", rsp_valid, busy, rsp_y, rsp_id, req_ready);
        end
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rstmid_no_rsp[%0d]: got valid=%b busy=%b want 0/0", c, rsp_valid, busy); end
            @(posedge clk); #1;
        end
        issue(3, 8'd6, 8'd7, ok);
        wait_rsp(ok);
        tests++; if (!ok || rsp_y !== 16'd42 || rsp_id !== 2'd3) begin fails++; $display("FAIL rstmid_after: got valid=%b y=%0d id=%0d want 1/42/3", ok, rsp_y, rsp_id); end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        int issued = 0;
        int nrsp   = 0;
        int accidx;
        exp_t e;
        exp_q.delete();
        for (int c = 0; c < 5000 && nrsp < 200; c++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] && issued < 200 && $urandom_range(0, 1) == 1) begin
                    req_a[8*i +: 8] = 8'($urandom);
                    req_b[8*i +: 8] = 8'($urandom);
                    req_valid[i]    = 1'b1;
                    issued++;
                end
            end
            #4;
            if (rsp_valid && rsp_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL rand_extra_rsp: got id=%0d y=%0d want no response", rsp_id, rsp_y);
                end else begin
                    e = exp_q.pop_front();
                    if (rsp_id !== e.id || rsp_y !== e.y) begin
                        fails++;
                        $display("FAIL rand_rsp[%0d]: got id=%0d y=%0d want id=%0d y=%0d", nrsp, rsp_id, rsp_y, e.id, e.y);
                    end
                end
                nrsp++;
            end
            accidx = -1;
            if (req_ready != 4'b0) begin
                tests++;
                if ((req_ready & ~req_valid) != 4'b0 || $countones(req_ready) != 1) begin fails++; $display("FAIL rand_onehot: got %b valid %b", req_ready, req_valid); end
                for (int i = 0; i < 4; i++) if (req_ready[i] && req_valid[i]) accidx = i;
            end
            if (accidx >= 0) begin
                e.id = 2'(accidx);
                e.y  = 16'(req_a[8*accidx +: 8]) * 16'(req_b[8*accidx +: 8]);
                exp_q.push_back(e);
            end
            @(posedge clk); #1;
            if (accidx >= 0) req_valid[accidx] = 1'b0;
        end
        req_valid = 4'b0;
        tests++; if (nrsp != 200 || exp_q.size() != 0) begin fails++; $display("FAIL rand_count: got %0d responses, %0d outstanding want 200/0", nrsp, exp_q.size()); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single();
        test_corners();
        test_contention();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
